// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply controller: request opcodes, FSM states and
// default widths.
package mul_hilo_ctrl_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned OpWDefault   = 3;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpMthi  = 3'd2;
  localparam logic [2:0] OpMtlo  = 3'd3;
  localparam logic [2:0] OpMfhi  = 3'd4;
  localparam logic [2:0] OpMflo  = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StMwb,
    StResp
  } state_e;

endpackage

// File: rtl/mul_hilo_ctrl_hilo_regfile.sv
// HI/LO architectural register pair with independent write enables; both clear on reset.
module mul_hilo_ctrl_hilo_regfile #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_wd,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_wd,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wd;
      if (lo_we) lo_q <= lo_wd;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// EX-stage multiply sequencer: drives the 2-stage multiplier, retires products into HI/LO
// and returns MFHI/MFLO data over a held response port.
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned OP_W   = OpWDefault
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_op,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  input  logic                flush,
  output logic                mul_en,
  output logic                mul_signed,
  output logic [DATA_W-1:0]   mul_x,
  output logic [DATA_W-1:0]   mul_y,
  input  logic [2*DATA_W-1:0] mul_result,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                busy
);

  localparam logic [OP_W-1:0] OpMultW  = OP_W'(OpMult);
  localparam logic [OP_W-1:0] OpMultuW = OP_W'(OpMultu);
  localparam logic [OP_W-1:0] OpMthiW  = OP_W'(OpMthi);
  localparam logic [OP_W-1:0] OpMtloW  = OP_W'(OpMtlo);
  localparam logic [OP_W-1:0] OpMfhiW  = OP_W'(OpMfhi);
  localparam logic [OP_W-1:0] OpMfloW  = OP_W'(OpMflo);

  state_e state_q, state_d;

  logic              is_mul, is_mthi, is_mtlo, is_mfhi, is_mflo, is_mf;
  logic              accept, retire;
  logic              hi_we, lo_we;
  logic [DATA_W-1:0] hi_wd, lo_wd;
  logic [DATA_W-1:0] hi, lo;
  logic [DATA_W-1:0] resp_data_q;

  assign is_mul  = (req_op == OpMultW) | (req_op == OpMultuW);
  assign is_mthi = (req_op == OpMthiW);
  assign is_mtlo = (req_op == OpMtloW);
  assign is_mfhi = (req_op == OpMfhiW);
  assign is_mflo = (req_op == OpMfloW);
  assign is_mf   = is_mfhi | is_mflo;

  assign accept     = req_valid & req_ready;
  assign mul_en     = accept & is_mul;
  assign mul_signed = (req_op == OpMultW);
  assign mul_x      = req_src1;
  assign mul_y      = req_src2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_mul)     state_d = StMwb;
        else if (accept && is_mf) state_d = StResp;
      end
      StMwb: begin
        if (flush)                state_d = StIdle;
        else if (accept && is_mul) state_d = StMwb;
        else                      state_d = StIdle;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // In MWB the product retires on the same edge a younger MT writes; the MT wins its register.
  always_comb begin
    req_ready = 1'b0;
    unique case (state_q)
      StIdle:  req_ready = 1'b1;
      StMwb:   req_ready = ~flush & ~(req_valid & is_mf);
      default: req_ready = 1'b0;
    endcase
    retire = (state_q == StMwb) & ~flush;
    hi_we  = retire | (accept & is_mthi);
    lo_we  = retire | (accept & is_mtlo);
    hi_wd  = (accept & is_mthi) ? req_src1 : mul_result[2*DATA_W-1:DATA_W];
    lo_wd  = (accept & is_mtlo) ? req_src1 : mul_result[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_data_q <= '0;
    end else if (accept && is_mf) begin
      resp_data_q <= is_mfhi ? hi : lo;
    end
  end

  assign resp_valid = (state_q == StResp);
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != StIdle);

  mul_hilo_ctrl_hilo_regfile #(
    .DATA_W(DATA_W)
  ) u_hilo_regfile (
    .clk   (clk),
    .resetn(resetn),
    .hi_we (hi_we),
    .hi_wd (hi_wd),
    .lo_we (lo_we),
    .lo_wd (lo_wd),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl: directed scenarios plus random traffic against a HI/LO reference
// model, with MF responses checked from a scoreboard queue by a separate monitor.
module tb_mul_hilo_ctrl;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] MTHI  = 3'd2;
  localparam logic [2:0] MTLO  = 3'd3;
  localparam logic [2:0] MFHI  = 3'd4;
  localparam logic [2:0] MFLO  = 3'd5;
  localparam logic [2:0] NOP   = 3'd7;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        flush = 1'b0;
  logic        mul_en;
  logic        mul_signed;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_result = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        busy;

  always #5 clk = ~clk;

  mul_hilo_ctrl #(
    .DATA_W(32),
    .OP_W  (3)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .flush     (flush),
    .mul_en    (mul_en),
    .mul_signed(mul_signed),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_result(mul_result),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .busy      (busy)
  );

  // Stand-in for the external multiplier: product appears the cycle after mul_en.
  always @(posedge clk) begin
    if (mul_en) begin
      if (mul_signed) mul_result <= $signed({{32{mul_x[31]}}, mul_x}) *
                                    $signed({{32{mul_y[31]}}, mul_y});
      else            mul_result <= {32'd0, mul_x} * {32'd0, mul_y};
    end
  end

  int compared = 0;
  int mismatched = 0;

  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_pend = 1'b0;
  logic [63:0] m_prod = '0;
  logic        m_resp = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    if (op == MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // One clock: drive at posedge+1, check and advance the model at negedge.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, input logic rr, output logic acc);
    logic exp_rdy, exp_mul, is_mf;
    req_valid = v; req_op = op; req_src1 = a; req_src2 = b; flush = fl; resp_ready = rr;
    @(negedge clk);
    is_mf = (op == MFHI) || (op == MFLO);
    if (m_resp)      exp_rdy = 1'b0;
    else if (m_pend) exp_rdy = !fl && !(v && is_mf);
    else             exp_rdy = 1'b1;
    acc     = v && exp_rdy;
    exp_mul = acc && (op == MULT || op == MULTU);
    check("handshake{ready,mul_en,busy,resp_valid}", {req_ready, mul_en, busy, resp_valid},
          {exp_rdy, exp_mul, m_pend | m_resp, m_resp});
    if (exp_mul) check("operands{signed,x,y}", {mul_signed, mul_x, mul_y}, {op == MULT, a, b});
    if (m_pend) begin
      if (!fl) {m_hi, m_lo} = m_prod;
      m_pend = 1'b0;
    end
    if (m_resp && rr) m_resp = 1'b0;
    if (acc) begin
      case (op)
        MULT, MULTU: begin m_pend = 1'b1; m_prod = ref_mul(op, a, b); end
        MTHI:        m_hi = a;
        MTLO:        m_lo = a;
        MFHI:        begin exp_q.push_back(m_hi); m_resp = 1'b1; end
        MFLO:        begin exp_q.push_back(m_lo); m_resp = 1'b1; end
        default:     ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rr);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) step(1'b1, op, a, b, 1'b0, rr, acc);
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL issue_timeout: op %0d never accepted, required acceptance", op);
    end
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, NOP, '0, '0, 1'b0, rr, acc);
  endtask

  task automatic do_reset();
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    resetn = 1'b0;
    #2;
    check("reset{resp_valid,busy,mul_en,resp_data}", {resp_valid, busy, mul_en, resp_data}, '0);
    m_hi = '0; m_lo = '0; m_pend = 1'b0; m_resp = 1'b0;
    exp_q.delete();
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic read_both();
    issue(MFHI, '0, '0, 1'b1);
    idle(1, 1'b1);
    issue(MFLO, '0, '0, 1'b1);
    idle(1, 1'b1);
  endtask

  // Response monitor: every cycle resp_valid is up, data must match the oldest expected MF.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && resp_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL resp_unexpected: got %h, required no response", resp_data);
        end else begin
          check("resp_data", resp_data, exp_q[0]);
          if (resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom);
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic acc;
    #1;
    do_reset();

    // Signed vs unsigned with the same operands.
    step(1'b1, MULT, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1, acc);
    read_both();
    step(1'b1, MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1, acc);
    read_both();

    // MF right after MULT stalls one cycle.
    step(1'b1, MULT, 32'd3, 32'd5, 1'b0, 1'b1, acc);
    step(1'b1, MFLO, '0, '0, 1'b0, 1'b1, acc);
    step(1'b1, MFLO, '0, '0, 1'b0, 1'b1, acc);
    idle(1, 1'b1);

    // Back-to-back multiplies.
    step(1'b1, MULT, 32'd7, 32'd6, 1'b0, 1'b1, acc);
    step(1'b1, MULT, 32'd2, 32'd2, 1'b0, 1'b1, acc);
    read_both();

    // Younger MTHI overrides product high half.
    step(1'b1, MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, acc);
    step(1'b1, MTHI, 32'hA5A5_A5A5, '0, 1'b0, 1'b1, acc);
    read_both();

    // Flush in MWB drops the product and a same-cycle request; then held response.
    step(1'b1, MULT, 32'd9, 32'd9, 1'b0, 1'b1, acc);
    step(1'b1, MTLO, 32'hDEAD_BEEF, '0, 1'b1, 1'b1, acc);
    issue(MFLO, '0, '0, 1'b0);
    idle(3, 1'b0);
    step(1'b1, MFHI, '0, '0, 1'b0, 1'b0, acc);
    idle(1, 1'b1);

    // Flush in IDLE is ignored; unknown op is consumed silently.
    step(1'b1, MTLO, 32'h0BAD_F00D, '0, 1'b1, 1'b1, acc);
    step(1'b1, 3'd6, 32'h1111_1111, '0, 1'b0, 1'b1, acc);
    read_both();

    // Reset mid-multiply discards the product.
    step(1'b1, MULT, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b1, acc);
    do_reset();
    read_both();

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), pick(), pick(),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, acc);
    end

    idle(4, 1'b1);
    read_both();
    idle(2, 1'b1);
    check("scoreboard_drained", 128'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
